sc_result_buffer: RTL
=====================

# sc_result_buffer

Two-entry registered output buffer that sits directly downstream of the combinational bitwise ALU units (AND, and the sibling OR/XOR/NOT units through the ALU result mux). It captures each ALU result with a valid/ready handshake and tags it with zero and negative flags. It presents the result to the register-file writeback and the status-flag consumer. It decouples the combinational ALU path from writeback back-pressure without losing or duplicating a result.

## Interface
Parameters:
- NUMBER_DATAWIDTH, 8: width of the ALU result; must be ≥ 2.

Ports (name, direction, width, meaning):
- SC_RESULTBUFFER_CLOCK_50, input, 1: single clock; all state updates on its rising edge.
- SC_RESULTBUFFER_RESET_InHigh, input, 1: reset; synchronous, active-high.
- SC_RESULTBUFFER_data_InBUS, input, NUMBER_DATAWIDTH: ALU result from upstream.
- SC_RESULTBUFFER_valid_In, input, 1: upstream result valid.
- SC_RESULTBUFFER_ready_Out, output, 1: buffer can accept a result this cycle.
- SC_RESULTBUFFER_data_OutBUS, output, NUMBER_DATAWIDTH: head result.
- SC_RESULTBUFFER_zero_Out, output, 1: head result equals 0.
- SC_RESULTBUFFER_negative_Out, output, 1: MSB of head result.
- SC_RESULTBUFFER_valid_Out, output, 1: head result valid.
- SC_RESULTBUFFER_ready_In, input, 1: downstream accepts head this cycle.
- SC_RESULTBUFFER_count_OutBUS, output, 2: occupancy, 0..2.

## Operation
- Storage: two entries, head and tail. Each entry holds data, zero and negative.
- Flag rules at capture:
  - zero = (data_InBUS == 0).
  - negative = data_InBUS[NUMBER_DATAWIDTH-1].
  - Flags are computed once at push and never recomputed.
- Push = valid_In & ready_Out. Pop = valid_Out & ready_In.
- State machine (registered):
  - EMPTY
    - push → ONE; the entry is written to head.
  - ONE
    - push only → FULL; the entry is written to tail.
    - pop only → EMPTY.
    - push and pop together → stays ONE; the new entry is written directly to head.
  - FULL
    - pop → ONE; tail moves to head.
    - push is impossible because ready_Out = 0.
- Combinational outputs:
  - ready_Out = (state != FULL) & ~RESET_InHigh.
  - valid_Out = (state != EMPTY).
  - count_OutBUS = 0, 1 or 2 for EMPTY, ONE or FULL.
- Stability rule: while valid_Out = 1 and ready_In = 0, data_OutBUS, zero_Out and negative_Out remain constant.
- When EMPTY, data/flag outputs hold the last popped value. Consumers must qualify them with valid_Out.
- valid_In while ready_Out = 0: input ignored and no state change. Upstream must hold the value.
- Ordering is strictly FIFO. No entry is dropped or duplicated.

## Timing
- Reset: on a clock edge with RESET_InHigh = 1:
  - State goes to EMPTY.
  - Both entries clear to data 0, zero 1, negative 0.
  - Outputs after that edge: valid_Out 0, count 0, data_OutBUS 0, zero_Out 1, negative_Out 0.
  - While reset is asserted, ready_Out = 0 and inputs are ignored.
- Reset mid-operation: contents are discarded at the reset edge, even if FULL. No pop is reported.
- Latency: a result pushed at edge N is visible on data_OutBUS with valid_Out = 1 after edge N (one cycle). There is no combinational path from data_InBUS to data_OutBUS.
- ready_Out depends only on registered state and reset. It does not depend on ready_In in the same cycle.
- Throughput: one result per cycle sustained when ready_In is held at 1.
- Back-pressure: downstream stall of k cycles absorbs at most 2 results. ready_Out deasserts the cycle after the second push.

## Test plan
- Reset then idle: assert RESET_InHigh for 2 cycles → valid_Out 0, ready_Out 0 during reset and 1 after, count 0, zero_Out 1.
- Single push (NUMBER_DATAWIDTH = 8): push 8'h00 with ready_In 1 → next cycle valid_Out 1, data 8'h00, zero 1, negative 0. The following cycle valid_Out 0.
- Fill and stall: ready_In 0, push 8'h81 then 8'h3C → count 2, ready_Out 0. Head holds 8'h81 with negative 1, stable while stalled. A third valid_In is ignored. Raise ready_In → 8'h81 then 8'h3C delivered in order.
- Simultaneous push/pop in ONE: head 8'h0F, ready_In 1, push 8'hF0 → count stays 1, next head 8'hF0 with negative 1.
- Streaming: 16 consecutive pushes of values 1..16 with ready_In 1 → 16 pops in order, one per cycle, count never exceeds 1.
- Reset while FULL: fill with 8'hAA and 8'h55, assert reset → after the edge, count 0 and valid_Out 0. A subsequent push of 8'h01 is the next delivered value.

Source files
------------

// File: rtl/sc_result_buffer_if.sv
// ---------------------------------------------------------------------------
// sc_result_buffer_if
//   Handshake bundle between the bitwise ALU result mux (upstream), the
//   result buffer, and the writeback / status-flag consumers (downstream).
//
//   Upstream side : SC_RESULTBUFFER_data_InBUS, SC_RESULTBUFFER_valid_In
//                   -> buffer, SC_RESULTBUFFER_ready_Out <- buffer
//   Downstream    : SC_RESULTBUFFER_data_OutBUS, SC_RESULTBUFFER_zero_Out,
//                   SC_RESULTBUFFER_negative_Out, SC_RESULTBUFFER_valid_Out,
//                   SC_RESULTBUFFER_count_OutBUS <- buffer,
//                   SC_RESULTBUFFER_ready_In -> buffer
//
//   Modport slave  is used by the buffer itself.
//   Modport master is used by whatever drives/consumes the buffer (e.g. a bench).
// ---------------------------------------------------------------------------
interface sc_result_buffer_if #(
  parameter int NUMBER_DATAWIDTH = 8
);
  logic [NUMBER_DATAWIDTH-1:0] SC_RESULTBUFFER_data_InBUS;
  logic                        SC_RESULTBUFFER_valid_In;
  logic                        SC_RESULTBUFFER_ready_Out;
  logic [NUMBER_DATAWIDTH-1:0] SC_RESULTBUFFER_data_OutBUS;
  logic                        SC_RESULTBUFFER_zero_Out;
  logic                        SC_RESULTBUFFER_negative_Out;
  logic                        SC_RESULTBUFFER_valid_Out;
  logic                        SC_RESULTBUFFER_ready_In;
  logic [1:0]                  SC_RESULTBUFFER_count_OutBUS;

  modport slave (
    input  SC_RESULTBUFFER_data_InBUS,
    input  SC_RESULTBUFFER_valid_In,
    output SC_RESULTBUFFER_ready_Out,
    output SC_RESULTBUFFER_data_OutBUS,
    output SC_RESULTBUFFER_zero_Out,
    output SC_RESULTBUFFER_negative_Out,
    output SC_RESULTBUFFER_valid_Out,
    input  SC_RESULTBUFFER_ready_In,
    output SC_RESULTBUFFER_count_OutBUS
  );

  modport master (
    output SC_RESULTBUFFER_data_InBUS,
    output SC_RESULTBUFFER_valid_In,
    input  SC_RESULTBUFFER_ready_Out,
    input  SC_RESULTBUFFER_data_OutBUS,
    input  SC_RESULTBUFFER_zero_Out,
    input  SC_RESULTBUFFER_negative_Out,
    input  SC_RESULTBUFFER_valid_Out,
    output SC_RESULTBUFFER_ready_In,
    input  SC_RESULTBUFFER_count_OutBUS
  );
endinterface

// File: rtl/sc_result_buffer.sv
// ---------------------------------------------------------------------------
// sc_result_buffer
//   Two-entry registered FIFO that captures bitwise ALU results with a
//   valid/ready handshake, tags each with zero/negative flags at capture,
//   and presents the oldest (head) entry to writeback. Breaks the
//   combinational path between the ALU and writeback back-pressure.
//
// Ports:
//   SC_RESULTBUFFER_CLOCK_50      : clock, rising-edge
//   SC_RESULTBUFFER_RESET_InHigh  : synchronous active-high reset
//   bus (sc_result_buffer_if.slave): upstream data/valid_In/ready_Out,
//                                   downstream data/zero/negative/valid_Out,
//                                   ready_In and occupancy count
// ---------------------------------------------------------------------------
module sc_result_buffer #(
  parameter int NUMBER_DATAWIDTH = 8
) (
  input logic               SC_RESULTBUFFER_CLOCK_50,
  input logic               SC_RESULTBUFFER_RESET_InHigh,
  sc_result_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [NUMBER_DATAWIDTH-1:0] head_data_q, head_data_d;
  logic                        head_zero_q, head_zero_d;
  logic                        head_neg_q, head_neg_d;
  logic [NUMBER_DATAWIDTH-1:0] tail_data_q, tail_data_d;
  logic                        tail_zero_q, tail_zero_d;
  logic                        tail_neg_q, tail_neg_d;

  logic                        ready_out;
  logic                        valid_out;
  logic [1:0]                  count_out;
  logic                        push;
  logic                        pop;
  logic                        in_zero;
  logic                        in_neg;

  // Flags are derived once from the incoming result and stored with it.
  assign in_zero = (bus.SC_RESULTBUFFER_data_InBUS == '0);
  assign in_neg  = bus.SC_RESULTBUFFER_data_InBUS[NUMBER_DATAWIDTH-1];

  // State and storage registers; reset discards any held results.
  always_ff @(posedge SC_RESULTBUFFER_CLOCK_50) begin
    if (SC_RESULTBUFFER_RESET_InHigh) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_zero_q <= 1'b1;
      head_neg_q  <= 1'b0;
      tail_data_q <= '0;
      tail_zero_q <= 1'b1;
      tail_neg_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_zero_q <= head_zero_d;
      head_neg_q  <= head_neg_d;
      tail_data_q <= tail_data_d;
      tail_zero_q <= tail_zero_d;
      tail_neg_q  <= tail_neg_d;
    end
  end

  // Next-state and entry update. The head only changes on a capture into
  // an empty/draining head or when the tail advances, so it stays frozen
  // while the consumer stalls and keeps the last popped value when EMPTY.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_zero_d = head_zero_q;
    head_neg_d  = head_neg_q;
    tail_data_d = tail_data_q;
    tail_zero_d = tail_zero_q;
    tail_neg_d  = tail_neg_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d     = ONE;
          head_data_d = bus.SC_RESULTBUFFER_data_InBUS;
          head_zero_d = in_zero;
          head_neg_d  = in_neg;
        end
      end
      ONE: begin
        if (push && pop) begin
          // Head leaves and is replaced by the new result in the same cycle.
          head_data_d = bus.SC_RESULTBUFFER_data_InBUS;
          head_zero_d = in_zero;
          head_neg_d  = in_neg;
        end else if (push) begin
          state_d     = FULL;
          tail_data_d = bus.SC_RESULTBUFFER_data_InBUS;
          tail_zero_d = in_zero;
          tail_neg_d  = in_neg;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d     = ONE;
          head_data_d = tail_data_q;
          head_zero_d = tail_zero_q;
          head_neg_d  = tail_neg_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs depend only on registered state (and reset for ready),
  // never on ready_In, so there is no combinational loop through the consumer.
  always_comb begin
    ready_out = (state_q != FULL) && !SC_RESULTBUFFER_RESET_InHigh;
    valid_out = (state_q != EMPTY);
    unique case (state_q)
      EMPTY:   count_out = 2'd0;
      ONE:     count_out = 2'd1;
      FULL:    count_out = 2'd2;
      default: count_out = 2'd0;
    endcase
    push = bus.SC_RESULTBUFFER_valid_In && ready_out;
    pop  = valid_out && bus.SC_RESULTBUFFER_ready_In;
  end

  assign bus.SC_RESULTBUFFER_ready_Out    = ready_out;
  assign bus.SC_RESULTBUFFER_valid_Out    = valid_out;
  assign bus.SC_RESULTBUFFER_count_OutBUS = count_out;
  assign bus.SC_RESULTBUFFER_data_OutBUS  = head_data_q;
  assign bus.SC_RESULTBUFFER_zero_Out     = head_zero_q;
  assign bus.SC_RESULTBUFFER_negative_Out = head_neg_q;

endmodule
